// File: rtl/fetch_sequencer.sv
// Next-PC controller for the pipelined MIPS fetch stage: sequences boot, imem wait states,
// branch/jump redirects, load-use stalls and exception entry, and drives the pipeline flushes.
module fetch_sequencer #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int                    WAIT_LIMIT   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_cur,
    output logic [DATA_WIDTH-1:0] pc_next,
    output logic                  pc_hold,
    output logic                  imem_req,
    input  logic                  imem_ready,
    input  logic                  load_use_stall,
    input  logic                  br_taken,
    input  logic [DATA_WIDTH-1:0] br_target,
    input  logic                  jump,
    input  logic [DATA_WIDTH-1:0] jump_target,
    input  logic                  exc_req,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exc_ack,
    output logic [DATA_WIDTH-1:0] epc,
    output logic [1:0]            exc_cause
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {BOOT, FETCH, WAIT, EXC} state_t;
    typedef enum logic [1:0] {PEND_NONE, PEND_JUMP, PEND_BR, PEND_EXC} pend_t;

    localparam logic [1:0] CAUSE_EXT     = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    state_t                  state, state_nxt;
    pend_t                   pend_kind, pend_kind_nxt, merged_kind;
    logic [DATA_WIDTH-1:0]   pend_addr, pend_addr_nxt, merged_addr;
    logic [CNT_W-1:0]        wait_cnt, cnt_nxt;
    logic                    exc_enter;
    logic [DATA_WIDTH-1:0]   epc_val;
    logic [1:0]              cause_val;
    logic [DATA_WIDTH-1:0]   pc_inc;

    assign pc_inc = pc_cur + DATA_WIDTH'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BOOT;
            pend_kind <= PEND_NONE;
            pend_addr <= '0;
            wait_cnt  <= '0;
            exc_ack   <= 1'b0;
            epc       <= '0;
            exc_cause <= 2'b00;
        end else begin
            state     <= state_nxt;
            pend_kind <= pend_kind_nxt;
            pend_addr <= pend_addr_nxt;
            wait_cnt  <= cnt_nxt;
            exc_ack   <= exc_enter;
            if (exc_enter) begin
                epc       <= epc_val;
                exc_cause <= cause_val;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        pend_kind_nxt = pend_kind;
        pend_addr_nxt = pend_addr;
        cnt_nxt       = wait_cnt;
        merged_kind   = pend_kind;
        merged_addr   = pend_addr;
        pc_next       = pc_cur;
        pc_hold       = 1'b1;
        imem_req      = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exc_enter     = 1'b0;
        epc_val       = epc;
        cause_val     = exc_cause;

        case (state)
            BOOT: begin
                pc_next   = RESET_VECTOR;
                pc_hold   = 1'b0;
                state_nxt = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (exc_req) begin
                    exc_enter  = 1'b1;
                    epc_val    = exc_pc;
                    cause_val  = CAUSE_EXT;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_nxt  = EXC;
                end else if (br_taken) begin
                    pc_next    = br_target;
                    pc_hold    = 1'b0;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (jump) begin
                    pc_next    = jump_target;
                    pc_hold    = 1'b0;
                    ifid_flush = 1'b1;
                end else if (load_use_stall) begin
                    idex_flush = 1'b1;
                end else if (imem_ready) begin
                    pc_next = pc_inc;
                    pc_hold = 1'b0;
                end else begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = WAIT;
                end
            end

            WAIT: begin
                imem_req = 1'b1;
                // Fold this cycle's request into the single pending slot by priority.
                if (exc_req) begin
                    merged_kind = PEND_EXC;
                    merged_addr = exc_pc;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                end else if (br_taken) begin
                    if (pend_kind != PEND_EXC) begin
                        merged_kind = PEND_BR;
                        merged_addr = br_target;
                    end
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (jump) begin
                    if (pend_kind == PEND_NONE || pend_kind == PEND_JUMP) begin
                        merged_kind = PEND_JUMP;
                        merged_addr = jump_target;
                    end
                    ifid_flush = 1'b1;
                end

                if (imem_ready) begin
                    cnt_nxt       = '0;
                    pend_kind_nxt = PEND_NONE;
                    state_nxt     = FETCH;
                    case (merged_kind)
                        PEND_EXC: begin
                            exc_enter  = 1'b1;
                            epc_val    = merged_addr;
                            cause_val  = CAUSE_EXT;
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                            state_nxt  = EXC;
                        end
                        PEND_BR, PEND_JUMP: begin
                            pc_next    = merged_addr;
                            pc_hold    = 1'b0;
                            ifid_flush = 1'b1;
                        end
                        default: begin
                            pc_next = pc_inc;
                            pc_hold = 1'b0;
                        end
                    endcase
                end else if (wait_cnt == CNT_W'(WAIT_LIMIT)) begin
                    exc_enter     = 1'b1;
                    epc_val       = pc_cur;
                    cause_val     = CAUSE_TIMEOUT;
                    ifid_flush    = 1'b1;
                    idex_flush    = 1'b1;
                    cnt_nxt       = '0;
                    pend_kind_nxt = PEND_NONE;
                    state_nxt     = EXC;
                end else begin
                    cnt_nxt       = wait_cnt + CNT_W'(1);
                    pend_kind_nxt = merged_kind;
                    pend_addr_nxt = merged_addr;
                end
            end

            EXC: begin
                pc_next       = EXC_VECTOR;
                pc_hold       = 1'b0;
                cnt_nxt       = '0;
                pend_kind_nxt = PEND_NONE;
                state_nxt     = FETCH;
            end

            default: state_nxt = BOOT;
        endcase

        // While reset is asserted the PC must stay parked at the reset vector.
        if (!rst) begin
            pc_next    = RESET_VECTOR;
            pc_hold    = 1'b1;
            imem_req   = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            exc_enter  = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: inputs driven after the falling edge, outputs
// sampled 1 time unit later; registered outputs observed in the cycle after the rising edge.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur, pc_next, br_target, jump_target, exc_pc, epc;
    logic        pc_hold, imem_req, imem_ready, load_use_stall, br_taken, jump, exc_req;
    logic        ifid_flush, idex_flush, exc_ack;
    logic [1:0]  exc_cause;

    int nchk = 0;
    int nerr = 0;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next), .pc_hold(pc_hold),
        .imem_req(imem_req), .imem_ready(imem_ready), .load_use_stall(load_use_stall),
        .br_taken(br_taken), .br_target(br_target), .jump(jump), .jump_target(jump_target),
        .exc_req(exc_req), .exc_pc(exc_pc), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exc_ack(exc_ack), .epc(epc), .exc_cause(exc_cause)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        imem_ready = 1'b0; load_use_stall = 1'b0; br_taken = 1'b0; jump = 1'b0; exc_req = 1'b0;
        br_target = '0; jump_target = '0; exc_pc = '0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; pc_cur = 32'h0; idle_inputs();
        repeat (3) next_cycle();
        #1;
        nchk++; if (pc_next !== 32'h0) begin $display("FAIL reset_pc_next: got %h want 00000000", pc_next); nerr++; end
        nchk++; if (pc_hold !== 1'b1) begin $display("FAIL reset_pc_hold: got %b want 1", pc_hold); nerr++; end
        nchk++; if (imem_req !== 1'b0) begin $display("FAIL reset_imem_req: got %b want 0", imem_req); nerr++; end
        nchk++; if ({ifid_flush, idex_flush} !== 2'b00) begin $display("FAIL reset_flushes: got %b want 00", {ifid_flush, idex_flush}); nerr++; end
        nchk++; if ({exc_ack, exc_cause} !== 3'b000 || epc !== 32'h0) begin $display("FAIL reset_exc_regs: got ack=%b cause=%b epc=%h want 0/00/0", exc_ack, exc_cause, epc); nerr++; end
        // Release reset; the first cycle is BOOT.
        rst = 1'b1; #1;
        nchk++; if (pc_hold !== 1'b0 || pc_next !== 32'h0 || imem_req !== 1'b0) begin $display("FAIL boot: got hold=%b pc=%h req=%b want 0/00000000/0", pc_hold, pc_next, imem_req); nerr++; end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            pc_cur = exp_pc; imem_ready = 1'b1; #1;
            exp_pc = exp_pc + 32'h4;
            nchk++; if (pc_next !== exp_pc || pc_hold !== 1'b0 || imem_req !== 1'b1) begin $display("FAIL seq_%0d: got pc=%h hold=%b req=%b want %h/0/1", i, pc_next, pc_hold, imem_req, exp_pc); nerr++; end
            nchk++; if ({ifid_flush, idex_flush} !== 2'b00) begin $display("FAIL seq_flush_%0d: got %b want 00", i, {ifid_flush, idex_flush}); nerr++; end
        end
    endtask

    task automatic test_wait_states();
        next_cycle(); idle_inputs(); pc_cur = 32'h40;
        for (int i = 0; i < 3; i++) begin
            #1;
            nchk++; if (pc_hold !== 1'b1 || imem_req !== 1'b1) begin $display("FAIL wait_hold_%0d: got hold=%b req=%b want 1/1", i, pc_hold, imem_req); nerr++; end
            next_cycle();
        end
        imem_ready = 1'b1; #1;
        nchk++; if (pc_next !== 32'h44 || pc_hold !== 1'b0) begin $display("FAIL wait_release: got pc=%h hold=%b want 00000044/0", pc_next, pc_hold); nerr++; end
    endtask

    task automatic test_redirect_priority();
        next_cycle(); idle_inputs(); pc_cur = 32'h48; imem_ready = 1'b1;
        br_taken = 1'b1; br_target = 32'h100; jump = 1'b1; jump_target = 32'h200; load_use_stall = 1'b1; #1;
        nchk++; if (pc_next !== 32'h100 || pc_hold !== 1'b0 || {ifid_flush, idex_flush} !== 2'b11) begin $display("FAIL br_priority: got pc=%h hold=%b fl=%b want 00000100/0/11", pc_next, pc_hold, {ifid_flush, idex_flush}); nerr++; end
        next_cycle(); br_taken = 1'b0; pc_cur = 32'h100; #1;
        nchk++; if (pc_next !== 32'h200 || pc_hold !== 1'b0 || {ifid_flush, idex_flush} !== 2'b10) begin $display("FAIL jump_priority: got pc=%h hold=%b fl=%b want 00000200/0/10", pc_next, pc_hold, {ifid_flush, idex_flush}); nerr++; end
        next_cycle(); jump = 1'b0; pc_cur = 32'h200; #1;
        nchk++; if (pc_hold !== 1'b1 || {ifid_flush, idex_flush} !== 2'b01) begin $display("FAIL load_use: got hold=%b fl=%b want 1/01", pc_hold, {ifid_flush, idex_flush}); nerr++; end
        next_cycle(); load_use_stall = 1'b0; #1;
        nchk++; if (pc_next !== 32'h204 || pc_hold !== 1'b0) begin $display("FAIL after_stall: got pc=%h hold=%b want 00000204/0", pc_next, pc_hold); nerr++; end
    endtask

    task automatic test_wait_jump();
        next_cycle(); idle_inputs(); pc_cur = 32'h80;
        next_cycle(); jump = 1'b1; jump_target = 32'h300; #1;
        nchk++; if (pc_hold !== 1'b1 || ifid_flush !== 1'b1) begin $display("FAIL wjump_arrive: got hold=%b ifid=%b want 1/1", pc_hold, ifid_flush); nerr++; end
        next_cycle(); jump = 1'b0; jump_target = 32'h0; #1;
        nchk++; if (pc_hold !== 1'b1 || ifid_flush !== 1'b0) begin $display("FAIL wjump_pending: got hold=%b ifid=%b want 1/0", pc_hold, ifid_flush); nerr++; end
        next_cycle(); imem_ready = 1'b1; #1;
        nchk++; if (pc_next !== 32'h300 || pc_hold !== 1'b0 || {ifid_flush, idex_flush} !== 2'b10) begin $display("FAIL wjump_redirect: got pc=%h hold=%b fl=%b want 00000300/0/10", pc_next, pc_hold, {ifid_flush, idex_flush}); nerr++; end
        next_cycle(); pc_cur = 32'h300; #1;
        nchk++; if (pc_next !== 32'h304 || ifid_flush !== 1'b0) begin $display("FAIL wjump_cleared: got pc=%h ifid=%b want 00000304/0", pc_next, ifid_flush); nerr++; end
    endtask

    task automatic test_timeout();
        next_cycle(); idle_inputs(); pc_cur = 32'h90; #1;
        nchk++; if (pc_hold !== 1'b1) begin $display("FAIL tmo_enter: got hold=%b want 1", pc_hold); nerr++; end
        for (int c = 1; c < 16; c++) begin
            next_cycle(); #1;
            nchk++; if (pc_hold !== 1'b1 || idex_flush !== 1'b0) begin $display("FAIL tmo_wait_%0d: got hold=%b idex=%b want 1/0", c, pc_hold, idex_flush); nerr++; end
        end
        next_cycle(); #1;
        nchk++; if ({ifid_flush, idex_flush} !== 2'b11 || pc_hold !== 1'b1) begin $display("FAIL tmo_fire: got fl=%b hold=%b want 11/1", {ifid_flush, idex_flush}, pc_hold); nerr++; end
        next_cycle(); #1;
        nchk++; if (exc_ack !== 1'b1 || epc !== 32'h90 || exc_cause !== 2'b10) begin $display("FAIL tmo_exc: got ack=%b epc=%h cause=%b want 1/00000090/10", exc_ack, epc, exc_cause); nerr++; end
        nchk++; if (pc_next !== 32'h8000_0180 || pc_hold !== 1'b0 || imem_req !== 1'b0) begin $display("FAIL tmo_vector: got pc=%h hold=%b req=%b want 80000180/0/0", pc_next, pc_hold, imem_req); nerr++; end
        next_cycle(); pc_cur = 32'h8000_0180; imem_ready = 1'b1; #1;
        nchk++; if (exc_ack !== 1'b0 || pc_next !== 32'h8000_0184 || imem_req !== 1'b1) begin $display("FAIL tmo_resume: got ack=%b pc=%h req=%b want 0/80000184/1", exc_ack, pc_next, imem_req); nerr++; end
    endtask

    task automatic test_wait_exception();
        next_cycle(); idle_inputs(); pc_cur = 32'h60;
        next_cycle(); exc_req = 1'b1; exc_pc = 32'h54; #1;
        nchk++; if ({ifid_flush, idex_flush} !== 2'b11 || pc_hold !== 1'b1) begin $display("FAIL wexc_arrive: got fl=%b hold=%b want 11/1", {ifid_flush, idex_flush}, pc_hold); nerr++; end
        next_cycle(); exc_req = 1'b0; exc_pc = 32'h0; imem_ready = 1'b1; #1;
        nchk++; if (pc_hold !== 1'b1 || {ifid_flush, idex_flush} !== 2'b11) begin $display("FAIL wexc_ready: got hold=%b fl=%b want 1/11", pc_hold, {ifid_flush, idex_flush}); nerr++; end
        next_cycle(); exc_req = 1'b1; exc_pc = 32'hAA; #1;
        nchk++; if (exc_ack !== 1'b1 || epc !== 32'h54 || exc_cause !== 2'b01 || pc_next !== 32'h8000_0180) begin $display("FAIL wexc_entry: got ack=%b epc=%h cause=%b pc=%h want 1/00000054/01/80000180", exc_ack, epc, exc_cause, pc_next); nerr++; end
        next_cycle(); exc_req = 1'b0; exc_pc = 32'h0; #1;
        nchk++; if (exc_ack !== 1'b0 || epc !== 32'h54 || exc_cause !== 2'b01) begin $display("FAIL wexc_pulse: got ack=%b epc=%h cause=%b want 0/00000054/01", exc_ack, epc, exc_cause); nerr++; end
    endtask

    task automatic test_fetch_exception_and_wrap();
        next_cycle(); idle_inputs(); pc_cur = 32'h70; imem_ready = 1'b1; exc_req = 1'b1; exc_pc = 32'h70; br_taken = 1'b1; br_target = 32'h500; #1;
        nchk++; if (pc_hold !== 1'b1 || {ifid_flush, idex_flush} !== 2'b11) begin $display("FAIL fexc_req: got hold=%b fl=%b want 1/11", pc_hold, {ifid_flush, idex_flush}); nerr++; end
        next_cycle(); idle_inputs(); #1;
        nchk++; if (exc_ack !== 1'b1 || epc !== 32'h70 || exc_cause !== 2'b01) begin $display("FAIL fexc_entry: got ack=%b epc=%h cause=%b want 1/00000070/01", exc_ack, epc, exc_cause); nerr++; end
        next_cycle(); pc_cur = 32'hFFFF_FFFC; imem_ready = 1'b1; #1;
        nchk++; if (pc_next !== 32'h0 || pc_hold !== 1'b0) begin $display("FAIL pc_wrap: got pc=%h hold=%b want 00000000/0", pc_next, pc_hold); nerr++; end
    endtask

    task automatic test_reset_mid();
        next_cycle(); idle_inputs(); pc_cur = 32'hC0;
        next_cycle(); br_taken = 1'b1; br_target = 32'h700;
        next_cycle(); idle_inputs(); rst = 1'b0; #1;
        nchk++; if (pc_hold !== 1'b1 || pc_next !== 32'h0 || imem_req !== 1'b0 || epc !== 32'h0 || exc_cause !== 2'b00) begin $display("FAIL mid_reset: got hold=%b pc=%h req=%b epc=%h cause=%b want 1/0/0/0/00", pc_hold, pc_next, imem_req, epc, exc_cause); nerr++; end
        next_cycle(); rst = 1'b1;
        next_cycle(); pc_cur = 32'h0; imem_ready = 1'b1; #1;
        nchk++; if (pc_next !== 32'h4 || pc_hold !== 1'b0 || ifid_flush !== 1'b0) begin $display("FAIL mid_reset_lost_pending: got pc=%h hold=%b ifid=%b want 00000004/0/0", pc_next, pc_hold, ifid_flush); nerr++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_redirect_priority();
        test_wait_jump();
        test_timeout();
        test_wait_exception();
        test_fetch_exception_and_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
